gatherer: RTL

- Reverse-direction counterpart of the column-0 dispatcher: collects AXI-Stream packets from the 4 tiles in the last column and merges them onto one egress stream.
- Packet-atomic round-robin arbitration: once a port is granted, its whole packet (through TLAST) passes before any other port is served.
- A 2-entry output FIFO registers the egress and removes any combinational path from downstream TREADY to tile TREADY.
- The source port index travels alongside the data on TID.

---
 rtl/gatherer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/gatherer.sv
// Gatherer: merges AXI-Stream packets from the 4 last-column tiles onto one egress
// stream. Packet-atomic round-robin arbitration, 2-entry registered output FIFO,
// source tile index carried on TID.
`timescale 1ns/1ps
module gatherer #(
    parameter int unsigned BW  = 32,
    parameter int unsigned BWB = 4
) (
    input  logic             clk_line,
    input  logic             clk_line_rst_low,
    input  logic [3:0]       stream_in_packet_TVALID,
    input  logic [4*BW-1:0]  stream_in_packet_TDATA,
    input  logic [4*BWB-1:0] stream_in_packet_TKEEP,
    input  logic [3:0]       stream_in_packet_TLAST,
    output logic [3:0]       stream_in_packet_TREADY,
    output logic             stream_out_packet_TVALID,
    output logic [BW-1:0]    stream_out_packet_TDATA,
    output logic [BWB-1:0]   stream_out_packet_TKEEP,
    output logic             stream_out_packet_TLAST,
    output logic [1:0]       stream_out_packet_TID,
    input  logic             stream_out_packet_TREADY,
    output logic             grant_valid,
    output logic [1:0]       grant_id,
    output logic [31:0]      packet_count
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e     r_state, w_state_next;
    logic [1:0] r_grant, w_grant_next;
    logic [1:0] r_last_grant, w_last_grant_next;

    // Arbiter result
    logic       w_found;
    logic [1:0] w_pick;

    // Granted-tile view of the ingress
    logic [BW-1:0]  w_in_data;
    logic [BWB-1:0] w_in_keep;
    logic           w_in_valid;
    logic           w_in_last;
    logic           w_in_ready;
    logic           w_push;
    logic           w_pop;

    // Output FIFO storage
    logic [BW-1:0]  r_fifo_data [2];
    logic [BWB-1:0] r_fifo_keep [2];
    logic           r_fifo_last [2];
    logic [1:0]     r_fifo_tid  [2];
    logic           r_wr_ptr;
    logic           r_rd_ptr;
    logic [1:0]     r_count, w_count_next;
    logic [31:0]    r_packet_count;

    // Round-robin search starting just after the last granted port
    always_comb begin
        logic [1:0] idx;
        w_found = 1'b0;
        w_pick  = r_last_grant;
        idx     = r_last_grant;
        for (int k = 1; k <= 4; k++) begin
            idx = r_last_grant + 2'(k);
            if (!w_found && stream_in_packet_TVALID[idx]) begin
                w_found = 1'b1;
                w_pick  = idx;
            end
        end
    end

    // Select the granted tile's payload
    always_comb begin
        w_in_data = '0;
        w_in_keep = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_grant == 2'(i)) begin
                w_in_data = stream_in_packet_TDATA[i*BW +: BW];
                w_in_keep = stream_in_packet_TKEEP[i*BWB +: BWB];
            end
        end
    end

    // Ready comes only from registered state, so no path from egress TREADY
    assign w_in_valid = stream_in_packet_TVALID[r_grant];
    assign w_in_last  = stream_in_packet_TLAST[r_grant];
    assign w_in_ready = (r_state == StLocked) && (r_count != 2'd2);
    assign w_push     = w_in_ready && w_in_valid;
    assign w_pop      = (r_count != 2'd0) && stream_out_packet_TREADY;

    assign stream_in_packet_TREADY = w_in_ready ? (4'b0001 << r_grant) : 4'b0000;

    // FSM next state: grant in IDLE, hold grant until the TLAST beat is accepted
    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_grant_next = w_pick;
                    w_state_next = StLocked;
                end
            end
            StLocked: begin
                if (w_push && w_in_last) begin
                    w_last_grant_next = r_grant;
                    w_state_next      = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM and arbitration state registers
    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            r_state      <= StIdle;
            r_grant      <= 2'd0;
            r_last_grant <= 2'd3;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // FIFO occupancy next value
    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_keep[i] <= '0;
                r_fifo_last[i] <= 1'b0;
                r_fifo_tid[i]  <= 2'd0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_in_data;
                r_fifo_keep[r_wr_ptr] <= w_in_keep;
                r_fifo_last[r_wr_ptr] <= w_in_last;
                r_fifo_tid[r_wr_ptr]  <= r_grant;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
        end
    end

    // Count completed egress packets, wrapping naturally
    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            r_packet_count <= 32'd0;
        end else if (w_pop && r_fifo_last[r_rd_ptr]) begin
            r_packet_count <= r_packet_count + 32'd1;
        end
    end

    assign stream_out_packet_TVALID = (r_count != 2'd0);
    assign stream_out_packet_TDATA  = r_fifo_data[r_rd_ptr];
    assign stream_out_packet_TKEEP  = r_fifo_keep[r_rd_ptr];
    assign stream_out_packet_TLAST  = r_fifo_last[r_rd_ptr];
    assign stream_out_packet_TID    = r_fifo_tid[r_rd_ptr];
    assign grant_valid              = (r_state == StLocked);
    assign grant_id                 = r_grant;
    assign packet_count             = r_packet_count;

endmodule
